mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 19 +
 rtl/arb_pick2.sv | 25 ++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory command encodings and arbiter FSM state type
package mem_pkg;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ISSUE  = 2'b01,
      RDWAIT = 2'b10
   } arb_state_e;

   // Only reads and writes ever reach the RAM; anything else is swallowed.
   function automatic logic is_legal_cmd(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-port winner selection (MEM_ARBITER_FIXED_PRIO_EN: port 0 always wins ties)
module arb_pick2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   // One-hot pick; a tie goes to the port not granted last unless priority is fixed.
   always_comb begin
      gnt = 2'b00;
      if (req0 && req1) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
         gnt = 2'b01;
`else
         gnt = last_grant ? 2'b01 : 2'b10;
`endif
      end else if (req0) begin
         gnt = 2'b01;
      end else if (req1) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-RAM arbiter (MEM_ARBITER_FIXED_PRIO_EN selects fixed priority)
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_0,
   input  logic [1:0]    cmd_0,
   input  logic [AW-1:0] addr_0,
   input  logic [DW-1:0] wdata_0,
   input  logic          req_1,
   input  logic [1:0]    cmd_1,
   input  logic [AW-1:0] addr_1,
   input  logic [DW-1:0] wdata_1,
   output logic          gnt_0,
   output logic [DW-1:0] rdata_0,
   output logic          rvalid_0,
   output logic          gnt_1,
   output logic [DW-1:0] rdata_1,
   output logic          rvalid_1,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_e    state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    rvalid_q, rvalid_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic [1:0]    mem_cmd_q, mem_cmd_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;

   logic [1:0]    pick;
   logic [1:0]    win_cmd;

   arb_pick2 u_pick (
      .req0       (req_0),
      .req1       (req_1),
      .last_grant (last_grant_q),
      .gnt        (pick)
   );

   assign win_cmd = pick[1] ? cmd_1 : cmd_0;

   // Next state and registered outputs; requests are only looked at in IDLE.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      gnt_d        = 2'b00;
      rvalid_d     = 2'b00;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      mem_cmd_d    = MNONE;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (pick != 2'b00) begin
               owner_d      = pick[1];
               last_grant_d = pick[1];
               gnt_d        = pick;
               mem_cmd_d    = is_legal_cmd(win_cmd) ? win_cmd : MNONE;
               mem_addr_d   = pick[1] ? addr_1 : addr_0;
               mem_wdata_d  = pick[1] ? wdata_1 : wdata_0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            state_d = (mem_cmd_q == MREAD) ? RDWAIT : IDLE;
         end
         RDWAIT: begin
            if (owner_q) begin
               rdata1_d = mem_rdata;
               rvalid_d = 2'b10;
            end else begin
               rdata0_d = mem_rdata;
               rvalid_d = 2'b01;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         gnt_q        <= 2'b00;
         rvalid_q     <= 2'b00;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         mem_cmd_q    <= MNONE;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         rvalid_q     <= rvalid_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         mem_cmd_q    <= mem_cmd_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign gnt_0     = gnt_q[0];
   assign gnt_1     = gnt_q[1];
   assign rvalid_0  = rvalid_q[0];
   assign rvalid_1  = rvalid_q[1];
   assign rdata_0   = rdata0_q;
   assign rdata_1   = rdata1_q;
   assign mem_cmd   = mem_cmd_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int DW = 16;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_0 = 1'b0, req_1 = 1'b0;
   logic [1:0]    cmd_0 = 2'b00, cmd_1 = 2'b00;
   logic [AW-1:0] addr_0 = '0, addr_1 = '0;
   logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
   logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
   logic [DW-1:0] rdata_0, rdata_1;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   logic [DW-1:0] ram [0:(1<<AW)-1];

   int vectors = 0;
   int miscompares = 0;

   mem_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_0     (req_0),
      .cmd_0     (cmd_0),
      .addr_0    (addr_0),
      .wdata_0   (wdata_0),
      .req_1     (req_1),
      .cmd_1     (cmd_1),
      .addr_1    (addr_1),
      .wdata_1   (wdata_1),
      .gnt_0     (gnt_0),
      .rdata_0   (rdata_0),
      .rvalid_0  (rvalid_0),
      .gnt_1     (gnt_1),
      .rdata_1   (rdata_1),
      .rvalid_1  (rvalid_1),
      .mem_cmd   (mem_cmd),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM model: read data valid the cycle after MREAD, writes land on the edge.
   always @(posedge clk) begin
      if (mem_cmd == MREAD) mem_rdata <= ram[mem_addr];
      else if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_w;
      for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
      ram[9'h010] = 16'hABCD;
      ram[9'h020] = 16'h1111;
      ram[9'h030] = 16'h2222;

      // Reset values
      step();
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("rst_gnt", {30'd0, gnt_1, gnt_0}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
      chk("rst_mem_cmd", 32'(mem_cmd), 32'(MNONE));
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_rdata0", 32'(rdata_0), 32'd0);
      chk("rst_rdata1", 32'(rdata_1), 32'd0);
      reset = 1'b0;
      step();

      // Single read, port 0, addr 010
      req_0 = 1'b1; cmd_0 = MREAD; addr_0 = 9'h010;
      step();
      chk("rd_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
      chk("rd_cmd", 32'(mem_cmd), 32'(MREAD));
      chk("rd_addr", 32'(mem_addr), 32'h010);
      req_0 = 1'b0;
      step();
      chk("rd_n2_cmd", 32'(mem_cmd), 32'(MNONE));
      chk("rd_n2_gnt", {30'd0, gnt_1, gnt_0}, 32'd0);
      chk("rd_n2_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
      step();
      chk("rd_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd1);
      chk("rd_rdata", 32'(rdata_0), 32'hABCD);
      step();
      chk("rd_rvalid_drop", {30'd0, rvalid_1, rvalid_0}, 32'd0);
      chk("rd_rdata_hold", 32'(rdata_0), 32'hABCD);

      // Single write, port 1, 1234 -> 005
      req_1 = 1'b1; cmd_1 = MWRITE; addr_1 = 9'h005; wdata_1 = 16'h1234;
      step();
      chk("wr_gnt", {30'd0, gnt_1, gnt_0}, 32'd2);
      chk("wr_cmd", 32'(mem_cmd), 32'(MWRITE));
      chk("wr_addr", 32'(mem_addr), 32'h005);
      chk("wr_wdata", 32'(mem_wdata), 32'h1234);
      req_1 = 1'b0;
      step();
      chk("wr_idle", 32'(dut.state_q), 32'(IDLE));
      chk("wr_no_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);

      // Read back 005 through port 0
      req_0 = 1'b1; cmd_0 = MREAD; addr_0 = 9'h005;
      step();
      chk("rb_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
      req_0 = 1'b0;
      step();
      step();
      chk("rb_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd1);
      chk("rb_rdata", 32'(rdata_0), 32'h1234);
      chk("rb_rdata1_hold", 32'(rdata_1), 32'd0);

      // Contention: fresh reset so port 0 wins the first tie
      reset = 1'b1;
      step();
      reset = 1'b0;
      req_0 = 1'b1; cmd_0 = MREAD; addr_0 = 9'h020;
      req_1 = 1'b1; cmd_1 = MREAD; addr_1 = 9'h030;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
         exp_w = 2'b01;
`else
         exp_w = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
         step();
         chk($sformatf("ct%0d_gnt", k), {30'd0, gnt_1, gnt_0}, {30'd0, exp_w});
         chk($sformatf("ct%0d_addr", k), 32'(mem_addr), exp_w[1] ? 32'h030 : 32'h020);
         step();
         step();
         chk($sformatf("ct%0d_rvalid", k), {30'd0, rvalid_1, rvalid_0}, {30'd0, exp_w});
         chk($sformatf("ct%0d_rdata", k), exp_w[1] ? 32'(rdata_1) : 32'(rdata_0),
             exp_w[1] ? 32'h2222 : 32'h1111);
      end
      req_0 = 1'b0; req_1 = 1'b0;
      step();
      chk("ct_quiet_gnt", {30'd0, gnt_1, gnt_0}, 32'd0);

      // Mid-read reset while in RDWAIT
      req_0 = 1'b1; cmd_0 = MREAD; addr_0 = 9'h010;
      step();
      chk("mr_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
      req_0 = 1'b0;
      step();
      chk("mr_rdwait", 32'(dut.state_q), 32'(RDWAIT));
      #2 reset = 1'b1;
      #1;
      chk("mr_state", 32'(dut.state_q), 32'(IDLE));
      chk("mr_cmd", 32'(mem_cmd), 32'(MNONE));
      chk("mr_rdata0", 32'(rdata_0), 32'd0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("mr%0d_rvalid", k), {30'd0, rvalid_1, rvalid_0}, 32'd0);
         chk($sformatf("mr%0d_gnt", k), {30'd0, gnt_1, gnt_0}, 32'd0);
      end

      // Illegal command 2'b11 from port 1
      req_1 = 1'b1; cmd_1 = 2'b11; addr_1 = 9'h007;
      step();
      chk("il_gnt", {30'd0, gnt_1, gnt_0}, 32'd2);
      chk("il_cmd", 32'(mem_cmd), 32'(MNONE));
      req_1 = 1'b0;
      step();
      chk("il_idle", 32'(dut.state_q), 32'(IDLE));
      chk("il_cmd2", 32'(mem_cmd), 32'(MNONE));
      chk("il_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
      step();
      chk("il_rvalid2", {30'd0, rvalid_1, rvalid_0}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
